// File: rtl/bcd_count_ctrl.sv
// Four-digit BCD counting chain with run/pause/clear sequencing, prescaled tick,
// per-digit carry pulses and terminal-count handling (halt in DONE or wrap to 0000).
module bcd_count_ctrl #(
    parameter logic [15:0] TERMINAL  = 16'h9675,
    parameter int          TICK_DIV  = 1,
    parameter int          DIV_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       wrap_en,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [2:0] carry_out,
    output logic       running,
    output logic       done,
    output logic       at_term
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [DIV_WIDTH-1:0] PRESC_MAX = DIV_WIDTH'(TICK_DIV - 1);

    state_t               state_reg, state_next;
    logic [3:0]           dig_reg [4];
    logic [3:0]           dig_next [4];
    logic [3:0]           dig_inc [4];
    logic [3:0]           inc_chain;
    logic [DIV_WIDTH-1:0] presc_reg, presc_next;
    logic [2:0]           carry_reg, carry_next;
    logic                 done_reg, done_next;
    logic [15:0]          value;
    logic                 tick;
    logic                 go;

    // inc_chain[i] = digit i receives an increment on a normal tick (full ripple in one cycle)
    assign inc_chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_chain
            assign inc_chain[gi] = inc_chain[gi-1] && (dig_reg[gi-1] == 4'd9);
        end
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign dig_inc[gi] = !inc_chain[gi]         ? dig_reg[gi] :
                                 (dig_reg[gi] == 4'd9)  ? 4'd0        :
                                                          dig_reg[gi] + 4'd1;
            assign value[gi*4 +: 4] = dig_reg[gi];
        end
    endgenerate

    assign tick = (presc_reg == PRESC_MAX);
    assign go   = start && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
            carry_reg <= '0;
            done_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dig_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            carry_reg <= carry_next;
            done_reg  <= done_next;
            for (int i = 0; i < 4; i++) begin
                dig_reg[i] <= dig_next[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        carry_next = '0;
        done_next  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dig_next[i] = dig_reg[i];
        end

        if (clear) begin
            state_next = ST_IDLE;
            presc_next = '0;
            for (int i = 0; i < 4; i++) begin
                dig_next[i] = '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (go) state_next = ST_RUN;
                end
                ST_RUN: begin
                    // stop outranks a coincident tick: prescaler and digits hold
                    if (stop) begin
                        state_next = ST_PAUSE;
                    end else if (tick) begin
                        presc_next = '0;
                        if (value == TERMINAL) begin
                            done_next = 1'b1;
                            if (wrap_en) begin
                                for (int i = 0; i < 4; i++) begin
                                    dig_next[i] = '0;
                                end
                            end else begin
                                state_next = ST_DONE;
                            end
                        end else begin
                            carry_next = inc_chain[3:1];
                            for (int i = 0; i < 4; i++) begin
                                dig_next[i] = dig_inc[i];
                            end
                        end
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (go) state_next = ST_RUN;
                end
                ST_DONE: begin
                    if (go) begin
                        state_next = ST_RUN;
                        presc_next = '0;
                        for (int i = 0; i < 4; i++) begin
                            dig_next[i] = '0;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign d0        = dig_reg[0];
    assign d1        = dig_reg[1];
    assign d2        = dig_reg[2];
    assign d3        = dig_reg[3];
    assign carry_out = carry_reg;
    assign done      = done_reg;
    assign running   = (state_reg == ST_RUN);
    assign at_term   = (value == TERMINAL);

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench: one DUT with TICK_DIV=1 for counting/terminal/priority scenarios,
// a second with TICK_DIV=4 for prescale and pause timing.
module tb_bcd_count_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, clear, wrap_en;
    logic [3:0] d0, d1, d2, d3;
    logic [2:0] carry_out;
    logic       running, done, at_term;

    logic       start4, stop4, clear4, wrap4;
    logic [3:0] e0, e1, e2, e3;
    logic [2:0] carry4;
    logic       running4, done4, at_term4;

    int checks = 0;
    int errors = 0;

    wire [15:0] val  = {d3, d2, d1, d0};
    wire [15:0] val4 = {e3, e2, e1, e0};

    bcd_count_ctrl #(.TERMINAL(16'h9675), .TICK_DIV(1), .DIV_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .wrap_en(wrap_en),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .carry_out(carry_out),
        .running(running), .done(done), .at_term(at_term)
    );

    bcd_count_ctrl #(.TERMINAL(16'h9675), .TICK_DIV(4), .DIV_WIDTH(16)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .stop(stop4), .clear(clear4), .wrap_en(wrap4),
        .d0(e0), .d1(e1), .d2(e2), .d3(e3), .carry_out(carry4),
        .running(running4), .done(done4), .at_term(at_term4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From IDLE/0000 on dut: start, then n ticks, then pause holding value n
    task automatic count_to(input int n);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (n) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; stop = 0; clear = 0; wrap_en = 0;
        start4 = 0; stop4 = 0; clear4 = 0; wrap4 = 0;
        repeat (2) step();
        checks++; if (val !== 16'h0000) begin errors++; $display("FAIL reset_val got %h exp 0000", val); end
        checks++; if ({running, done, carry_out} !== 5'b0) begin errors++; $display("FAIL reset_flags got run=%b done=%b carry=%b exp 0", running, done, carry_out); end
        checks++; if (at_term !== 1'b0) begin errors++; $display("FAIL reset_at_term got %b exp 0", at_term); end
        checks++; if ({val4, running4} !== 17'h0) begin errors++; $display("FAIL reset_dut4 got val=%h run=%b exp 0000/0", val4, running4); end
        rst = 1'b0;
        step();
        $display("reset: val=%h running=%b at_term=%b", val, running, at_term);
    endtask

    task automatic test_ripple();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (running !== 1'b1 || val !== 16'h0000) begin errors++; $display("FAIL start_latency got run=%b val=%h exp 1/0000", running, val); end
        repeat (998) step();
        checks++; if (val !== 16'h0998) begin errors++; $display("FAIL ripple_0998 got %h exp 0998", val); end
        step();
        checks++; if (val !== 16'h0999 || carry_out !== 3'b000) begin errors++; $display("FAIL ripple_0999 got %h c=%b exp 0999 c=000", val, carry_out); end
        step();
        checks++; if (val !== 16'h1000 || carry_out !== 3'b111) begin errors++; $display("FAIL ripple_1000 got %h c=%b exp 1000 c=111", val, carry_out); end
        step();
        checks++; if (val !== 16'h1001 || carry_out !== 3'b000) begin errors++; $display("FAIL ripple_1001 got %h c=%b exp 1001 c=000", val, carry_out); end
        $display("ripple: val=%h carry_out=%b", val, carry_out);
        do_clear();
        checks++; if (val !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL clear_run got %h run=%b exp 0000/0", val, running); end
    endtask

    task automatic test_reset_mid();
        count_to(347);
        checks++; if (val !== 16'h0347) begin errors++; $display("FAIL pre_reset_val got %h exp 0347", val); end
        start = 1'b1;
        step();
        start = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++; if (val !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset got %h run=%b done=%b exp 0000/0/0", val, running, done); end
        $display("reset_mid: val=%h running=%b", val, running);
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_prescale();
        start4 = 1'b1;
        step();                                   // edge 0
        start4 = 1'b0;
        checks++; if (running4 !== 1'b1) begin errors++; $display("FAIL pre_run got %b exp 1", running4); end
        repeat (3) step();                        // edges 1..3
        checks++; if (e0 !== 4'd0) begin errors++; $display("FAIL pre_edge3 got %0d exp 0", e0); end
        step();                                   // edge 4
        checks++; if (e0 !== 4'd1) begin errors++; $display("FAIL pre_edge4 got %0d exp 1", e0); end
        repeat (4) step();                        // edges 5..8
        checks++; if (e0 !== 4'd2) begin errors++; $display("FAIL pre_edge8 got %0d exp 2", e0); end
        step();                                   // edge 9: prescaler 0->1
        stop4 = 1'b1;
        step();                                   // edge 10: pause, prescaler held at 1
        stop4 = 1'b0;
        checks++; if (running4 !== 1'b0) begin errors++; $display("FAIL pre_pause got %b exp 0", running4); end
        repeat (4) step();                        // edges 11..14
        start4 = 1'b1;
        step();                                   // edge 15: resume
        start4 = 1'b0;
        repeat (2) step();                        // edges 16,17: prescaler 2,3
        checks++; if (e0 !== 4'd2) begin errors++; $display("FAIL pre_edge17 got %0d exp 2", e0); end
        step();                                   // edge 18: tick
        checks++; if (e0 !== 4'd3) begin errors++; $display("FAIL pre_edge18 got %0d exp 3", e0); end
        $display("prescale: val=%h running=%b", val4, running4);
    endtask

    task automatic test_terminal_halt();
        do_clear();
        wrap_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9674) step();
        checks++; if (val !== 16'h9674 || at_term !== 1'b0) begin errors++; $display("FAIL halt_9674 got %h at=%b exp 9674/0", val, at_term); end
        step();
        checks++; if (val !== 16'h9675 || at_term !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL halt_9675 got %h at=%b done=%b exp 9675/1/0", val, at_term, done); end
        step();
        checks++; if (val !== 16'h9675 || done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL halt_done got %h done=%b run=%b exp 9675/1/0", val, done, running); end
        step();
        checks++; if (val !== 16'h9675 || done !== 1'b0) begin errors++; $display("FAIL halt_hold got %h done=%b exp 9675/0", val, done); end
        stop = 1'b1;
        repeat (3) step();
        stop = 1'b0;
        checks++; if (val !== 16'h9675 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL halt_stop got %h run=%b exp 9675/0", val, running); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (val !== 16'h0000 || running !== 1'b1) begin errors++; $display("FAIL halt_restart got %h run=%b exp 0000/1", val, running); end
        step();
        checks++; if (val !== 16'h0001) begin errors++; $display("FAIL halt_first got %h exp 0001", val); end
        $display("terminal_halt: val=%h running=%b", val, running);
    endtask

    task automatic test_terminal_wrap();
        do_clear();
        wrap_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9674) step();
        checks++; if (val !== 16'h9674 || done !== 1'b0) begin errors++; $display("FAIL wrap_9674 got %h done=%b exp 9674/0", val, done); end
        step();
        checks++; if (val !== 16'h9675 || done !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL wrap_9675 got %h done=%b run=%b exp 9675/0/1", val, done, running); end
        step();
        checks++; if (val !== 16'h0000 || done !== 1'b1 || running !== 1'b1 || carry_out !== 3'b000) begin errors++; $display("FAIL wrap_0000 got %h done=%b run=%b c=%b exp 0000/1/1/000", val, done, running, carry_out); end
        step();
        checks++; if (val !== 16'h0001 || done !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL wrap_0001 got %h done=%b run=%b exp 0001/0/1", val, done, running); end
        $display("terminal_wrap: val=%h done=%b running=%b", val, done, running);
    endtask

    task automatic test_priority();
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        checks++; if (val !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL prio_clear got %h run=%b exp 0000/0", val, running); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (val !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL prio_idle_stop got %h run=%b exp 0000/0", val, running); end
        start = 1'b1;
        step();
        start = 1'b1; stop = 1'b1;
        step();                                   // start+stop in RUN -> PAUSE, no increment
        checks++; if (val !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL prio_run_both got %h run=%b exp 0000/0", val, running); end
        step();                                   // start+stop in PAUSE -> stay PAUSE
        start = 1'b0; stop = 1'b0;
        checks++; if (val !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL prio_pause_both got %h run=%b exp 0000/0", val, running); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (val !== 16'h0001 || running !== 1'b1) begin errors++; $display("FAIL prio_resume got %h run=%b exp 0001/1", val, running); end
        $display("priority: val=%h running=%b", val, running);
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_reset_mid();
        test_prescale();
        test_terminal_halt();
        test_terminal_wrap();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
